// File: rtl/seq_event_logger.sv
// Timestamped event logger: counts sequence-detector hits and queues their records in a small FIFO.
// Define SEQ_LOG_DELTA_EN to record cycles since the previous accepted event instead of the absolute timestamp.
module seq_event_logger #(
    parameter int TS_W       = 16,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            det_in,
    input  logic            clr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [TS_W-1:0] out_data,
    output logic [7:0]      evt_cnt,
    output logic [7:0]      drop_cnt,
    output logic            ovf
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {S_EMPTY, S_ACTIVE, S_FULL} state_t;

    state_t                state;
    logic [TS_W-1:0]       ts;
    logic [TS_W-1:0]       mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_nxt;
    logic                  event_req;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic [TS_W-1:0]       record;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [TS_W-1:0] sat_inc_ts(input logic [TS_W-1:0] v);
        return (v == {TS_W{1'b1}}) ? v : v + TS_W'(1);
    endfunction

    // A full FIFO still accepts an event when the head leaves on the same edge.
    always_comb begin
        event_req = reset & en & det_in;
        pop       = out_valid & out_ready;
        push      = event_req & ((state != S_FULL) | pop);
        drop      = event_req & (state == S_FULL) & ~pop;
        count_nxt = count + CW'(push) - CW'(pop);
    end

`ifdef SEQ_LOG_DELTA_EN
    logic [TS_W-1:0] delta;

    // Restarts at 1 the cycle after an accepted event; dropped events leave it running.
    always_ff @(posedge clk) begin
        if (!reset) begin
            delta <= '0;
        end else if (push) begin
            delta <= TS_W'(1);
        end else begin
            delta <= sat_inc_ts(delta);
        end
    end

    assign record = delta;
`else
    assign record = ts;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= record;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ts        <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            state     <= S_EMPTY;
            out_valid <= 1'b0;
            evt_cnt   <= '0;
            drop_cnt  <= '0;
            ovf       <= 1'b0;
        end else begin
            ts <= ts + TS_W'(1);
            if (push) begin
                wr_ptr  <= wr_ptr + DEPTH_LOG2'(1);
                evt_cnt <= sat_inc8(evt_cnt);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            count     <= count_nxt;
            out_valid <= (count_nxt != '0);
            if (count_nxt == '0) begin
                state <= S_EMPTY;
            end else if (count_nxt == FULL_CNT) begin
                state <= S_FULL;
            end else begin
                state <= S_ACTIVE;
            end
            // A drop on a clearing edge leaves exactly that one drop recorded.
            if (drop) begin
                ovf      <= 1'b1;
                drop_cnt <= clr ? 8'd1 : sat_inc8(drop_cnt);
            end else if (clr) begin
                ovf      <= 1'b0;
                drop_cnt <= '0;
            end
        end
    end

    assign out_data = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: doc/seq_event_logger.md
SEQ_EVENT_LOGGER -- requirements
Module: seq_event_logger

Interface
REQ-001 SHALL have parameter TS_W, default 16, timestamp/delta width in bits (8..32).
REQ-002 SHALL have parameter DEPTH_LOG2, default 2, log2 of FIFO depth (1..4); depth = 2**DEPTH_LOG2.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port en  input  1  detection enable; when 0, det_in is ignored.
REQ-006 SHALL have port det_in  input  1  detection pulse from the upstream Mealy sequence detector (yout).
REQ-007 SHALL have port clr  input  1  synchronous clear of ovf and drop_cnt.
REQ-008 SHALL have port out_valid  output  1  FIFO head entry available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts head entry.
REQ-010 SHALL have port out_data  output  TS_W  head entry value; 0 when out_valid=0.
REQ-011 SHALL have port evt_cnt  output  8  accepted events, saturating at 255.
REQ-012 SHALL have port drop_cnt  output  8  dropped events, saturating at 255.
REQ-013 SHALL have port ovf  output  1  sticky: at least one event dropped.

Function
REQ-014 SHALL run a free TS_W-bit timestamp counter: 0 in the first cycle after reset release, +1 per cycle, wrapping from 2**TS_W-1 to 0; en does not affect it.
REQ-015 SHALL treat every rising edge with en=1 and det_in=1 as one event; consecutive high cycles are separate events.
REQ-016 SHALL push the event's record (REQ-030) into the FIFO on that edge; out_valid rises the following cycle (latency 1).
REQ-017 SHALL pop the head on an edge where out_valid=1 and out_ready=1; out_ready while out_valid=0 has no effect.
REQ-018 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-019 SHALL use occupancy FSM EMPTY -> ACTIVE on push; ACTIVE -> FULL when count reaches depth; ACTIVE -> EMPTY when count reaches 0; FULL -> ACTIVE on pop.
REQ-020 SHALL, on simultaneous push and pop in any non-EMPTY state, accept both with count unchanged, including in FULL.
REQ-021 SHALL, on an event in FULL without a same-edge pop, drop it: no write, ovf set, drop_cnt +1 (saturating), evt_cnt unchanged.
REQ-022 SHALL increment evt_cnt (saturating at 255) on each accepted push.
REQ-023 SHALL, on clr=1, zero ovf and drop_cnt on that edge; a drop on the same edge takes precedence (ovf=1, drop_cnt=1).
REQ-024 SHALL wrap FIFO read/write pointers modulo depth with no gaps.

Reset
REQ-025 SHALL, on an edge with reset=0, set timestamp, FIFO pointers and count, evt_cnt, drop_cnt, ovf and the delta reference to 0 and the FSM to EMPTY.
REQ-026 SHALL hold out_valid=0 and out_data=0 during and in the first cycle after reset.
REQ-027 SHALL discard FIFO contents on reset mid-operation; det_in on a reset edge is ignored.
REQ-028 SHALL not reset FIFO storage contents; the outputs do not depend on them.

Configuration
REQ-029 SHALL use macro SEQ_LOG_DELTA_EN to select the recorded value.
REQ-030 SHALL, without SEQ_LOG_DELTA_EN, record the absolute timestamp value on the event edge.
REQ-031 SHALL, with SEQ_LOG_DELTA_EN, record cycles since the previous accepted event, saturating at 2**TS_W-1; the first event after reset records cycles since reset release; only accepted events update the reference.

Verification
REQ-032 SHALL cover: det_in=1 at ts=5 only, out_ready=1 -> out_valid=1 for one cycle at ts=6, out_data=5, evt_cnt=1.
REQ-033 SHALL cover: DEPTH_LOG2=2, out_ready=0, det_in high ts=3..8 -> 4 entries 3,4,5,6; drop_cnt=2, ovf=1, evt_cnt=4.
REQ-034 SHALL cover: FIFO full, det_in=1 with out_ready=1 on the same edge -> pop and push both accepted, drop_cnt unchanged.
REQ-035 SHALL cover: with SEQ_LOG_DELTA_EN, events at ts=4, 10, 11 -> out_data 4, 6, 1.
REQ-036 SHALL cover: reset=0 for one cycle with 3 entries queued -> out_valid=0 next cycle; evt_cnt=0, drop_cnt=0, ovf=0, ts restarts at 0.
REQ-037 SHALL cover: ovf=1, clr=1 with no drop -> ovf=0, drop_cnt=0 next cycle; en=0 with det_in=1 -> no push.
